inst_phase_sequencer: RTL

//   Parametrised instruction sequencer for the ALU datapath. It captures an instruction word on
//   a rising edge of the START switch and walks it through NPHASE one-hot phase strobes
//   (default decode/execute/write), each PH_CYC cycles long.

---
 rtl/seq_pkg.sv | 34 +++
 rtl/inst_fifo.sv | 66 ++++++
 rtl/inst_phase_sequencer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : seq_pkg                                                          |
// | Brief   : State encoding and width helper shared by the instruction       |
// |           sequencer and the decoder/ALU phase users.                       |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package seq_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_PH    = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    FETCH = ST_FETCH,
    PH    = ST_PH
  } seq_state_e;

  // Ceiling log2 usable in constant expressions; clog2(1) == 0.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/inst_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : inst_fifo                                                        |
// | Brief   : Synchronous pending-instruction FIFO. A push on the same edge as  |
// |           a pop is accepted even when full.                                |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module inst_fifo
  import seq_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           data_i,
  output logic [W-1:0]           head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [clog2(DEPTH):0]  count_o
);

  localparam int AW = clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Storage array: written on accepted pushes, contents irrelevant when empty.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^AW).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/inst_phase_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : inst_phase_sequencer                                             |
// | Brief   : Captures an instruction on a START rising edge and walks it      |
// |           through NPHASE one-hot phase strobes of PH_CYC cycles each.      |
// |           Starts arriving while busy are queued in inst_fifo.              |
// | Options : SEQ_STEP_EN adds input STEP; sequencing advances only when high. |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module inst_phase_sequencer
  import seq_pkg::*;
#(
  parameter int INST_W = 8,
  parameter int NPHASE = 3,
  parameter int PH_CYC = 1,
  parameter int QDEPTH = 2
) (
  input  logic                    CLK,
  input  logic                    RST,
`ifdef SEQ_STEP_EN
  input  logic                    STEP,
`endif
  input  logic                    START,
  input  logic [INST_W-1:0]       SW_INST,
  output logic [INST_W-1:0]       INST,
  output logic [NPHASE-1:0]       PHASE,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    DROP,
  output logic [clog2(QDEPTH):0]  QCOUNT
);

  localparam int PW = (clog2(NPHASE) > 0) ? clog2(NPHASE) : 1;
  localparam int CW = clog2(PH_CYC) + 1;
  localparam logic [PW-1:0] P_LAST = PW'(NPHASE - 1);
  localparam logic [CW-1:0] C_LAST = CW'(PH_CYC - 1);

  seq_state_e            state_q;
  logic [PW-1:0]         p_q;
  logic [CW-1:0]         c_q;
  logic [INST_W-1:0]     inst_q;
  logic [NPHASE-1:0]     phase_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  drop_q;
  logic                  start_q;

  logic                  req;
  logic                  step;
  logic                  seq_end;
  logic                  bypass;
  logic                  drop_d;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [INST_W-1:0]     fifo_head;
  logic [clog2(QDEPTH):0] fifo_count;

`ifdef SEQ_STEP_EN
  assign step = STEP;
`else
  assign step = 1'b1;
`endif

  function automatic logic [NPHASE-1:0] onehot(input logic [PW-1:0] idx);
    return NPHASE'(1) << idx;
  endfunction

  assign req     = START & ~start_q;
  assign seq_end = (state_q == PH) & step & (p_q == P_LAST) & (c_q == C_LAST);

  // A request landing on the final edge with nothing queued is handed straight
  // to the next sequence; otherwise it would be stranded in the FIFO while the
  // FSM returns to IDLE.
  assign bypass    = seq_end & req & fifo_empty;
  assign fifo_pop  = seq_end & ~fifo_empty;
  assign fifo_push = req & busy_q & ~bypass;
  assign drop_d    = req & busy_q & fifo_full & ~fifo_pop;

  inst_fifo #(
    .W     (INST_W),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .data_i  (SW_INST),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Edge detect, sequencing FSM, phase/hold counters and registered strobes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      p_q     <= '0;
      c_q     <= '0;
      inst_q  <= '0;
      phase_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
      start_q <= 1'b1;
    end else begin
      start_q <= START;
      done_q  <= 1'b0;
      drop_q  <= drop_d;
      case (state_q)
        IDLE: begin
          if (req) begin
            inst_q  <= SW_INST;
            busy_q  <= 1'b1;
            state_q <= FETCH;
          end
        end
        FETCH: begin
          if (step) begin
            p_q     <= '0;
            c_q     <= '0;
            phase_q <= onehot('0);
            state_q <= PH;
          end
        end
        PH: begin
          if (step) begin
            if (c_q == C_LAST) begin
              if (p_q == P_LAST) begin
                phase_q <= '0;
                done_q  <= 1'b1;
                p_q     <= '0;
                c_q     <= '0;
                if (!fifo_empty) begin
                  inst_q  <= fifo_head;
                  state_q <= FETCH;
                end else if (req) begin
                  inst_q  <= SW_INST;
                  state_q <= FETCH;
                end else begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
                end
              end else begin
                p_q     <= p_q + 1'b1;
                c_q     <= '0;
                phase_q <= onehot(p_q + 1'b1);
              end
            end else begin
              c_q <= c_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // An IDLE request must never find queued work behind it.
  always_ff @(posedge CLK) begin
    if (!RST && (state_q == IDLE) && req) begin
      assert (fifo_empty);
    end
  end

  assign INST   = inst_q;
  assign PHASE  = phase_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign DROP   = drop_q;
  assign QCOUNT = fifo_count;

endmodule
`default_nettype wire
